// File: rtl/tv80_snap_defs.sv
// Shared definitions for the register-file snapshot engine and the savestate controller.
// Holds the state encoding, the default register count and the stream byte count.
package tv80_snap_defs;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAVE_RD = 3'd1,
        SAVE_H  = 3'd2,
        SAVE_L  = 3'd3,
        LOAD_H  = 3'd4,
        LOAD_L  = 3'd5,
        LOAD_WR = 3'd6,
        DONE    = 3'd7
    } snap_state_t;

    localparam int unsigned SNAP_NREGS = 8;
    localparam int unsigned SNAP_BYTES = 2 * SNAP_NREGS;

endpackage

// File: rtl/tv80_reg_snap.sv
// Dumps the TV80 register file to a byte stream and restores it from one,
// high byte then low byte per entry, entry 0 first.
module tv80_reg_snap
    import tv80_snap_defs::*;
#(
    parameter int unsigned NREGS = SNAP_NREGS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_save,
    input  logic       start_load,
    output logic       busy,
    output logic       done,
    output logic       rf_sel,
    output logic [2:0] rf_addr,
    input  logic [7:0] rf_doh,
    input  logic [7:0] rf_dol,
    output logic [7:0] rf_dih,
    output logic [7:0] rf_dil,
    output logic       rf_we,
    output logic [7:0] so_data,
    output logic       so_valid,
    input  logic       so_ready,
    input  logic [7:0] si_data,
    input  logic       si_valid,
    output logic       si_ready
);

    snap_state_t state, state_nx;
    logic [2:0]  idx, idx_nx;
    logic [7:0]  hold_h, hold_h_nx;
    logic [7:0]  hold_l, hold_l_nx;
    logic        last;

    assign last = (idx == 3'(NREGS - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            idx    <= '0;
            hold_h <= '0;
            hold_l <= '0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            hold_h <= hold_h_nx;
            hold_l <= hold_l_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        hold_h_nx = hold_h;
        hold_l_nx = hold_l;
        case (state)
            IDLE: begin
                // save takes priority when both starts arrive together
                if (start_save) begin
                    state_nx = SAVE_RD;
                    idx_nx   = '0;
                end else if (start_load) begin
                    state_nx = LOAD_H;
                    idx_nx   = '0;
                end
            end
            SAVE_RD: begin
                hold_h_nx = rf_doh;
                hold_l_nx = rf_dol;
                state_nx  = SAVE_H;
            end
            SAVE_H: begin
                if (so_ready) state_nx = SAVE_L;
            end
            SAVE_L: begin
                if (so_ready) begin
                    if (last) begin
                        state_nx = DONE;
                    end else begin
                        idx_nx   = idx + 3'd1;
                        state_nx = SAVE_RD;
                    end
                end
            end
            LOAD_H: begin
                if (si_valid) begin
                    hold_h_nx = si_data;
                    state_nx  = LOAD_L;
                end
            end
            LOAD_L: begin
                if (si_valid) begin
                    hold_l_nx = si_data;
                    state_nx  = LOAD_WR;
                end
            end
            LOAD_WR: begin
                if (last) begin
                    state_nx = DONE;
                end else begin
                    idx_nx   = idx + 3'd1;
                    state_nx = LOAD_H;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs decode straight from registered state so reset clears them on the same edge.
    assign busy     = (state != IDLE);
    assign rf_sel   = busy;
    assign rf_addr  = rf_sel ? idx : '0;
    assign done     = (state == DONE);
    assign rf_we    = (state == LOAD_WR);
    assign rf_dih   = hold_h;
    assign rf_dil   = hold_l;
    assign so_valid = (state == SAVE_H) || (state == SAVE_L);
    assign so_data  = (state == SAVE_H) ? hold_h :
                      (state == SAVE_L) ? hold_l : '0;
    assign si_ready = (state == LOAD_H) || (state == LOAD_L);

endmodule

// File: doc/tv80_reg_snap.md
TV80_REG_SNAP -- requirements
Module: tv80_reg_snap

Interface
REQ-001 SHALL have parameter NREGS, default 8, meaning number of 16-bit register-file entries.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start_save  input  1  pulse; begin dump of the register file to the byte-out stream.
REQ-005 SHALL have port start_load  input  1  pulse; begin restore of the register file from the byte-in stream.
REQ-006 SHALL have port busy  output  1  high while an operation is in progress; the owner uses it to stall the CPU.
REQ-007 SHALL have port done  output  1  one-cycle pulse when an operation completes.
REQ-008 SHALL have port rf_sel  output  1  high while this block owns the register-file ports.
REQ-009 SHALL have port rf_addr  output  3  register-file entry index, driving both read and write addresses.
REQ-010 SHALL have port rf_doh  input  8  combinational high-byte read data at rf_addr.
REQ-011 SHALL have port rf_dol  input  8  combinational low-byte read data at rf_addr.
REQ-012 SHALL have port rf_dih  output  8  high-byte write data.
REQ-013 SHALL have port rf_dil  output  8  low-byte write data.
REQ-014 SHALL have port rf_we  output  1  write strobe for both halves; the owner ANDs it into WEH and WEL and forces CEN.
REQ-015 SHALL have port so_data  output  8  byte-out data.
REQ-016 SHALL have port so_valid  output  1  byte-out valid.
REQ-017 SHALL have port so_ready  input  1  byte-out ready.
REQ-018 SHALL have port si_data  input  8  byte-in data.
REQ-019 SHALL have port si_valid  input  1  byte-in valid.
REQ-020 SHALL have port si_ready  output  1  byte-in ready.

Function
REQ-021 SHALL implement states IDLE, SAVE_RD, SAVE_H, SAVE_L, LOAD_H, LOAD_L, LOAD_WR and DONE, with a 3-bit entry index idx.
REQ-022 SHALL transfer bytes in stream order entry 0 high, entry 0 low, ..., entry NREGS-1 low (2*NREGS bytes).
REQ-023 SHALL, in IDLE, go to SAVE_RD with idx=0 on start_save and to LOAD_H with idx=0 on start_load; if both are asserted in the same cycle, save wins.
REQ-024 SHALL ignore start_save and start_load whenever busy is high.
REQ-025 SHALL, in SAVE_RD (one cycle), latch rf_doh and rf_dol at rf_addr=idx into hold registers, then go to SAVE_H.
REQ-026 SHALL, in SAVE_H, hold so_valid=1 with so_data=hold_h; on so_valid&so_ready, go to SAVE_L.
REQ-027 SHALL, in SAVE_L, hold so_data=hold_l; on so_valid&so_ready, go to DONE if idx=NREGS-1, else increment idx and go to SAVE_RD.
REQ-028 SHALL keep so_data and so_valid stable while so_ready is low.
REQ-029 SHALL, in LOAD_H, drive si_ready=1 and capture si_data into hold_h on si_valid&si_ready, then go to LOAD_L; in LOAD_L, capture into hold_l, then go to LOAD_WR.
REQ-030 SHALL, in LOAD_WR, assert rf_we for exactly one cycle with rf_addr=idx, rf_dih=hold_h and rf_dil=hold_l, then go to DONE if idx=NREGS-1, else increment idx and go to LOAD_H.
REQ-031 SHALL drive si_ready=0 outside LOAD_H and LOAD_L, and so_valid=0 outside SAVE_H and SAVE_L.
REQ-032 SHALL, in DONE, pulse done for one cycle and return to IDLE.
REQ-033 SHALL set busy=rf_sel=1 in every state except IDLE; rf_addr SHALL be idx whenever rf_sel=1.
REQ-034 SHALL make save latency with so_ready tied high exactly 3*NREGS+1 cycles from the start_save edge to the done pulse.
REQ-035 SHALL never write the register file during a save, and SHALL write it exactly NREGS times per load.

Reset
REQ-036 SHALL, with reset_n low at a clock edge, force state=IDLE, idx=0, holds=0, and busy, done, rf_sel, rf_we, so_valid, si_ready=0 and so_data, rf_dih, rf_dil, rf_addr=0, including mid-operation.
REQ-037 SHALL perform no further register-file writes after a mid-load reset; entries already written SHALL keep their values.

Structure
REQ-038 SHALL place the state encoding, NREGS default and byte count 2*NREGS in shared include tv80_snap_defs, reused by the savestate controller.
REQ-039 SHALL be one flat module with no sub-module; the CPU-versus-snap port mux belongs to the integrating wrapper.

Verification
REQ-040 SHALL cover save with regfile entry k = {8'h10+k, 8'h20+k} and so_ready=1 -> 16 bytes 10,20,11,21,...,17,27; done at cycle 25; rf_we never high.
REQ-041 SHALL cover load of bytes A0..AF with si_valid=1 -> entry k = {A0+2k, A1+2k}; 8 rf_we pulses; done pulse; busy low afterwards.
REQ-042 SHALL cover save with so_ready toggling 1/0 every cycle -> identical byte sequence, so_data stable across stalls, no byte lost or duplicated.
REQ-043 SHALL cover start_save and start_load in the same cycle, then start_load mid-save -> save only; second start ignored.
REQ-044 SHALL cover reset_n low after 5 load bytes -> next cycle outputs at reset values, entries 0-1 written, entries 2-7 unchanged.
REQ-045 SHALL cover a load with si_valid gaps of 3 cycles -> same result as REQ-041, rf_we only in LOAD_WR.
